syn_gpu_job_sched: RTL and testbench

Parametrised GPU job scheduler for the grapheme visual cortex. It accepts jobs over the local bus into a `P_JOB_DEPTH`-deep queue and dispatches them one at a time to `P_NUM_ENGINES` drawing engines, selected by the job action field. It routes the dispatched engine's pixel-gateway traffic to the shared pixel gateway. It sits between the vcortex local bus and the GPU engines (euclid and successors), and replaces single-engine, unqueued job registers.

---
 rtl/syn_gpu_pkg.sv | 27 ++
 rtl/syn_gpu_job_fifo.sv | 68 ++++++
 rtl/syn_gpu_job_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_syn_gpu_job_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/syn_gpu_pkg.sv
// Shared types and register map for the GPU job scheduler.
package syn_gpu_pkg;

  localparam int BFFR_W     = 16;
  localparam int JOB_DATA_W = 7 * BFFR_W;

  localparam logic [7:0]  ADDR_CONTROL = 8'h00;
  localparam logic [7:0]  ADDR_STATUS  = 8'h01;
  localparam logic [7:0]  ADDR_BFFR0   = 8'h08;
  localparam logic [31:0] RD_UNMAPPED  = 32'hDEADBABE;

  typedef logic [1:0] action_t;

  // bffr[7] sits in the MSBs so the packed job data reads {bffr7,...,bffr1}
  typedef struct packed {
    action_t                 action;
    logic [7:1][BFFR_W-1:0]  bffr;
  } job_t;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, RUN} sched_state_t;

  // JOB_BFFR_0..7 occupy word addresses 0x08..0x0F
  function automatic logic is_bffr(input logic [7:0] addr);
    return addr[7:3] == 5'b00001;
  endfunction

endpackage

// File: rtl/syn_gpu_job_fifo.sv
// Synchronous show-ahead FIFO of job_t with flush. A write into a full
// FIFO is accepted when a read happens in the same cycle.
module syn_gpu_job_fifo
  import syn_gpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       wr_en,
  input  job_t                       wr_job,
  input  logic                       rd_en,
  output job_t                       rd_job,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  job_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_wr, do_rd;

  assign full      = cnt_q == (AW+1)'(DEPTH);
  assign empty     = cnt_q == '0;
  assign do_rd     = rd_en && !empty;
  assign do_wr     = wr_en && (!full || do_rd);
  assign rd_job    = mem_q[rd_ptr_q];
  assign occupancy = cnt_q;

  // pointer / count update; flush wins over everything
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  // control state registers
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // storage needs no reset: contents are only visible through the count
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem_q[wr_ptr_q] <= wr_job;
  end

endmodule

// File: rtl/syn_gpu_job_sched.sv
// GPU job scheduler: local-bus register file, job queue, dispatch FSM and
// pixel-gateway mux. Optional macro SYN_GPU_JOB_SCHED_TIMEOUT_EN adds a
// WAIT_BUSY watchdog that abandons a job the engine never picks up.
module syn_gpu_job_sched
  import syn_gpu_pkg::*;
#(
  parameter int P_NUM_ENGINES = 2,
  parameter int P_JOB_DEPTH   = 4,
  parameter int P_PXL_W       = 16,
  parameter int P_X_W         = 10,
  parameter int P_Y_W         = 9
) (
  input  logic                                  clk_ir,
  input  logic                                  rst_sync_l,
  input  logic                                  lb_wr_en,
  input  logic                                  lb_rd_en,
  input  logic [7:0]                            lb_addr,
  input  logic [31:0]                           lb_wr_data,
  output logic                                  lb_wr_valid,
  output logic                                  lb_rd_valid,
  output logic [31:0]                           lb_rd_data,
  output logic [P_NUM_ENGINES-1:0]              eng_job_start,
  output logic [JOB_DATA_W-1:0]                 eng_job_data,
  input  logic [P_NUM_ENGINES-1:0]              eng_busy,
  input  logic [P_NUM_ENGINES-1:0][P_PXL_W-1:0] eng_pxl,
  input  logic [P_NUM_ENGINES-1:0][P_X_W-1:0]   eng_posx,
  input  logic [P_NUM_ENGINES-1:0][P_Y_W-1:0]   eng_posy,
  input  logic [P_NUM_ENGINES-1:0]              eng_pxl_wr_valid,
  input  logic [P_NUM_ENGINES-1:0]              eng_pxl_rd_valid,
  output logic [P_NUM_ENGINES-1:0]              eng_ready,
  output logic [P_PXL_W-1:0]                    gw_pxl,
  output logic [P_X_W-1:0]                      gw_posx,
  output logic [P_Y_W-1:0]                      gw_posy,
  output logic                                  gw_pxl_wr_valid,
  output logic                                  gw_pxl_rd_valid,
  input  logic                                  gw_ready
);

  localparam int OCC_W = $clog2(P_JOB_DEPTH) + 1;

  // bus-side registers
  logic                   enable_q, enable_d;
  logic [7:1][BFFR_W-1:0] bffr_q, bffr_d;
  action_t                act_stg_q, act_stg_d;
  logic                   ovf_q, ovf_d, bad_q, bad_d, tmo_q, tmo_d;
  logic                   wr_valid_q, wr_valid_d, rd_valid_q, rd_valid_d;
  logic [31:0]            rd_data_q, rd_data_d;

  // dispatch FSM registers
  sched_state_t              state_q, state_d;
  job_t                      job_q, job_d;
  logic [P_NUM_ENGINES-1:0]  start_q, start_d;
`ifdef SYN_GPU_JOB_SCHED_TIMEOUT_EN
  logic [7:0]                tmo_cnt_q, tmo_cnt_d;
`endif

  logic             wr_ctrl, flush, commit, rd_status, pop, busy_act;
  logic             set_ovf, set_bad, set_tmo;
  logic             q_full, q_empty;
  logic [OCC_W-1:0] occ;
  job_t             head, new_job;
  logic [31:0]      status, rd_mux;
  logic [15:0]      unused_wr_hi;

  assign wr_ctrl      = lb_wr_en && (lb_addr == ADDR_CONTROL);
  assign flush        = wr_ctrl && lb_wr_data[1];
  assign commit       = lb_wr_en && (lb_addr == ADDR_BFFR0);
  assign rd_status    = lb_rd_en && (lb_addr == ADDR_STATUS);
  assign pop          = (state_q == IDLE) && enable_q && !q_empty && !flush;
  assign set_ovf      = commit && q_full && !pop;
  assign new_job      = {lb_wr_data[1:0], bffr_q};
  assign unused_wr_hi = lb_wr_data[31:16];

  syn_gpu_job_fifo #(.DEPTH(P_JOB_DEPTH)) u_fifo (
    .clk       (clk_ir),
    .rst_l     (rst_sync_l),
    .wr_en     (commit),
    .wr_job    (new_job),
    .rd_en     (pop),
    .rd_job    (head),
    .flush     (flush),
    .occupancy (occ),
    .full      (q_full),
    .empty     (q_empty)
  );

  // busy of the engine selected by the latched job (0 for out-of-range actions)
  always_comb begin
    busy_act = 1'b0;
    for (int e = 0; e < P_NUM_ENGINES; e++)
      if (int'(job_q.action) == e) busy_act = eng_busy[e];
  end

  // STATUS word and read-data mux
  always_comb begin
    status                      = '0;
    status[P_NUM_ENGINES-1:0]   = eng_busy;
    status[15:8]                = 8'(occ);
    status[16]                  = q_full;
    status[17]                  = q_empty;
    status[18]                  = ovf_q;
    status[19]                  = bad_q;
    status[20]                  = tmo_q;
    rd_mux = RD_UNMAPPED;
    if (lb_addr == ADDR_CONTROL)     rd_mux = {31'b0, enable_q};
    else if (lb_addr == ADDR_STATUS) rd_mux = status;
    else if (lb_addr == ADDR_BFFR0)  rd_mux = {30'b0, act_stg_q};
    else if (is_bffr(lb_addr))       rd_mux = {16'b0, bffr_q[lb_addr[2:0]]};
  end

  // register-file next state; sticky set beats clear-on-read
  always_comb begin
    enable_d   = enable_q;
    bffr_d     = bffr_q;
    act_stg_d  = act_stg_q;
    ovf_d      = (ovf_q & ~rd_status) | set_ovf;
    bad_d      = (bad_q & ~rd_status) | set_bad;
    tmo_d      = (tmo_q & ~rd_status) | set_tmo;
    wr_valid_d = lb_wr_en;
    rd_valid_d = lb_rd_en;
    rd_data_d  = lb_rd_en ? rd_mux : '0;
    if (wr_ctrl) enable_d = lb_wr_data[0];
    if (commit)  act_stg_d = lb_wr_data[1:0];
    if (lb_wr_en && is_bffr(lb_addr) && (lb_addr != ADDR_BFFR0))
      bffr_d[lb_addr[2:0]] = lb_wr_data[15:0];
  end

  // register file
  always_ff @(posedge clk_ir) begin
    if (!rst_sync_l) begin
      enable_q   <= 1'b0;
      bffr_q     <= '0;
      act_stg_q  <= '0;
      ovf_q      <= 1'b0;
      bad_q      <= 1'b0;
      tmo_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      enable_q   <= enable_d;
      bffr_q     <= bffr_d;
      act_stg_q  <= act_stg_d;
      ovf_q      <= ovf_d;
      bad_q      <= bad_d;
      tmo_q      <= tmo_d;
      wr_valid_q <= wr_valid_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // dispatch FSM next state; the start pulse is registered with the LAUNCH entry
  always_comb begin
    state_d   = state_q;
    job_d     = job_q;
    start_d   = '0;
    set_bad   = 1'b0;
    set_tmo   = 1'b0;
`ifdef SYN_GPU_JOB_SCHED_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    unique case (state_q)
      IDLE: if (pop) begin
        state_d = LAUNCH;
        job_d   = head;
        for (int e = 0; e < P_NUM_ENGINES; e++)
          start_d[e] = (int'(head.action) == e);
      end
      LAUNCH: begin
        if (int'(job_q.action) >= P_NUM_ENGINES) begin
          state_d = IDLE;
          set_bad = 1'b1;
        end else begin
          state_d = WAIT_BUSY;
`ifdef SYN_GPU_JOB_SCHED_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      WAIT_BUSY: begin
        if (busy_act) state_d = RUN;
`ifdef SYN_GPU_JOB_SCHED_TIMEOUT_EN
        // 255 WAIT_BUSY cycles without busy abandon the job
        else if (tmo_cnt_q == 8'hFE) begin
          state_d = IDLE;
          set_tmo = 1'b1;
        end else tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
      end
      RUN: if (!busy_act) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // dispatch FSM state and registered outputs
  always_ff @(posedge clk_ir) begin
    if (!rst_sync_l) begin
      state_q   <= IDLE;
      job_q     <= '0;
      start_q   <= '0;
`ifdef SYN_GPU_JOB_SCHED_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      job_q     <= job_d;
      start_q   <= start_d;
`ifdef SYN_GPU_JOB_SCHED_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  // combinational pixel mux: only the active engine sees the gateway
  always_comb begin
    gw_pxl          = '0;
    gw_posx         = '0;
    gw_posy         = '0;
    gw_pxl_wr_valid = 1'b0;
    gw_pxl_rd_valid = 1'b0;
    eng_ready       = '0;
    if ((state_q == WAIT_BUSY) || (state_q == RUN)) begin
      for (int e = 0; e < P_NUM_ENGINES; e++) begin
        if (int'(job_q.action) == e) begin
          gw_pxl          = eng_pxl[e];
          gw_posx         = eng_posx[e];
          gw_posy         = eng_posy[e];
          gw_pxl_wr_valid = eng_pxl_wr_valid[e];
          gw_pxl_rd_valid = eng_pxl_rd_valid[e];
          eng_ready[e]    = gw_ready;
        end
      end
    end
  end

  assign lb_wr_valid   = wr_valid_q;
  assign lb_rd_valid   = rd_valid_q;
  assign lb_rd_data    = rd_data_q;
  assign eng_job_start = start_q;
  assign eng_job_data  = job_q.bffr;

endmodule

// File: tb/tb_syn_gpu_job_sched.sv
// Directed bench for syn_gpu_job_sched (2 engines, depth 4).
module tb_syn_gpu_job_sched;

  localparam int N  = 2;
  localparam int D  = 4;
  localparam int PW = 16;
  localparam int XW = 10;
  localparam int YW = 9;

  logic                 clk_ir = 1'b0;
  logic                 rst_sync_l = 1'b0;
  logic                 lb_wr_en = 1'b0;
  logic                 lb_rd_en = 1'b0;
  logic [7:0]           lb_addr = '0;
  logic [31:0]          lb_wr_data = '0;
  logic                 lb_wr_valid, lb_rd_valid;
  logic [31:0]          lb_rd_data;
  logic [N-1:0]         eng_job_start;
  logic [111:0]         eng_job_data;
  logic [N-1:0]         eng_busy = '0;
  logic [N-1:0][PW-1:0] eng_pxl = '0;
  logic [N-1:0][XW-1:0] eng_posx = '0;
  logic [N-1:0][YW-1:0] eng_posy = '0;
  logic [N-1:0]         eng_pxl_wr_valid = '0;
  logic [N-1:0]         eng_pxl_rd_valid = '0;
  logic [N-1:0]         eng_ready;
  logic [PW-1:0]        gw_pxl;
  logic [XW-1:0]        gw_posx;
  logic [YW-1:0]        gw_posy;
  logic                 gw_pxl_wr_valid, gw_pxl_rd_valid;
  logic                 gw_ready = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;
  logic [N-1:0] start_acc;

  always #5 clk_ir = ~clk_ir;

  syn_gpu_job_sched #(
    .P_NUM_ENGINES(N), .P_JOB_DEPTH(D), .P_PXL_W(PW), .P_X_W(XW), .P_Y_W(YW)
  ) dut (
    .clk_ir(clk_ir), .rst_sync_l(rst_sync_l),
    .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .lb_addr(lb_addr),
    .lb_wr_data(lb_wr_data), .lb_wr_valid(lb_wr_valid),
    .lb_rd_valid(lb_rd_valid), .lb_rd_data(lb_rd_data),
    .eng_job_start(eng_job_start), .eng_job_data(eng_job_data),
    .eng_busy(eng_busy), .eng_pxl(eng_pxl), .eng_posx(eng_posx),
    .eng_posy(eng_posy), .eng_pxl_wr_valid(eng_pxl_wr_valid),
    .eng_pxl_rd_valid(eng_pxl_rd_valid), .eng_ready(eng_ready),
    .gw_pxl(gw_pxl), .gw_posx(gw_posx), .gw_posy(gw_posy),
    .gw_pxl_wr_valid(gw_pxl_wr_valid), .gw_pxl_rd_valid(gw_pxl_rd_valid),
    .gw_ready(gw_ready)
  );

  task automatic tick();
    @(posedge clk_ir);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lb_wr(input logic [7:0] a, input logic [31:0] d);
    lb_addr    = a;
    lb_wr_data = d;
    lb_wr_en   = 1'b1;
    tick();
    lb_wr_en   = 1'b0;
    chk("wr_ack", 128'(lb_wr_valid), 128'(1'b1));
  endtask

  task automatic lb_rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    lb_addr  = a;
    lb_rd_en = 1'b1;
    tick();
    lb_rd_en = 1'b0;
    chk("rd_ack", 128'(lb_rd_valid), 128'(1'b1));
    chk(tag, 128'(lb_rd_data), 128'(exp));
  endtask

  initial begin
    // ---- reset state
    tick();
    tick();
    chk("rst_wr_valid", 128'(lb_wr_valid), 128'(0));
    chk("rst_rd_valid", 128'(lb_rd_valid), 128'(0));
    chk("rst_rd_data",  128'(lb_rd_data), 128'(0));
    chk("rst_start",    128'(eng_job_start), 128'(0));
    chk("rst_job_data", 128'(eng_job_data), 128'(0));
    chk("rst_eng_ready",128'(eng_ready), 128'(0));
    chk("rst_gw_pxl",   128'(gw_pxl), 128'(0));
    rst_sync_l = 1'b1;
    tick();

    lb_rd_chk("status_idle", 8'h01, 32'h0002_0000);
    lb_rd_chk("unmapped",    8'h03, 32'hDEAD_BABE);

    // ---- basic dispatch with bffr1..7 = 1..7
    for (int i = 1; i <= 7; i++) lb_wr(8'(8 + i), 32'(i));
    lb_rd_chk("bffr3_readback", 8'h0B, 32'h0000_0003);
    lb_wr(8'h00, 32'h1);
    lb_wr(8'h08, 32'h0);
    chk("start_not_early", 128'(eng_job_start), 128'(0));
    tick();
    chk("start_eng0", 128'(eng_job_start), 128'(2'b01));
    chk("job_data", 128'(eng_job_data), 128'(112'h0007_0006_0005_0004_0003_0002_0001));
    tick();
    chk("start_one_cycle", 128'(eng_job_start), 128'(0));
    // WAIT_BUSY on engine 0: mux follows engine 0
    eng_pxl[0] = 16'hABCD;
    eng_posx[0] = 10'h155;
    eng_pxl_wr_valid[0] = 1'b1;
    gw_ready = 1'b1;
    #1;
    chk("mux0_pxl",  128'(gw_pxl), 128'(16'hABCD));
    chk("mux0_posx", 128'(gw_posx), 128'(10'h155));
    chk("mux0_ready",128'(eng_ready), 128'(2'b01));
    eng_busy = 2'b01;
    tick();
    eng_busy = 2'b00;
    tick();
    chk("idle_gw_zero",    128'(gw_pxl), 128'(0));
    chk("idle_ready_zero", 128'(eng_ready), 128'(0));

    // ---- overflow: 5 commits into depth-4 queue with enable off
    lb_wr(8'h00, 32'h0);
    for (int i = 0; i < 5; i++) lb_wr(8'h08, 32'h0);
    lb_rd_chk("status_ovf",     8'h01, 32'h0005_0400);
    lb_rd_chk("status_ovf_clr", 8'h01, 32'h0001_0400);
    // commit into full queue in the same cycle as a pop is accepted
    lb_wr(8'h00, 32'h1);
    lb_wr(8'h08, 32'h0);
    lb_rd_chk("status_full_pop", 8'h01, 32'h0001_0400);
    // flush the rest with enable off; finish the in-flight job
    lb_wr(8'h00, 32'h2);
    lb_rd_chk("ctrl_flush_selfclr", 8'h00, 32'h0);
    eng_busy = 2'b01;
    tick();
    eng_busy = 2'b00;
    tick();
    lb_rd_chk("status_flushed", 8'h01, 32'h0002_0000);

    // ---- action 1 while engine 0 drives the gateway
    lb_wr(8'h09, 32'h1111);
    lb_wr(8'h00, 32'h1);
    lb_wr(8'h08, 32'h1);
    tick();
    chk("start_eng1", 128'(eng_job_start), 128'(2'b10));
    chk("job_bffr1",  128'(eng_job_data[15:0]), 128'(16'h1111));
    tick();
    eng_pxl[1] = 16'h1234;
    eng_posx[1] = 10'h02A;
    eng_posy[1] = 9'h01F;
    eng_pxl_rd_valid[1] = 1'b1;
    #1;
    chk("mux1_pxl",   128'(gw_pxl), 128'(16'h1234));
    chk("mux1_posx",  128'(gw_posx), 128'(10'h02A));
    chk("mux1_posy",  128'(gw_posy), 128'(9'h01F));
    chk("mux1_wrv",   128'(gw_pxl_wr_valid), 128'(0));
    chk("mux1_rdv",   128'(gw_pxl_rd_valid), 128'(1));
    chk("mux1_ready", 128'(eng_ready), 128'(2'b10));
    eng_busy = 2'b10;
    tick();
    eng_busy = 2'b00;
    tick();

    // ---- bad action 3 followed by a good job
    lb_wr(8'h00, 32'h0);
    lb_wr(8'h08, 32'h3);
    lb_wr(8'h09, 32'h00AA);
    lb_wr(8'h08, 32'h0);
    lb_wr(8'h00, 32'h1);
    tick();
    chk("bad_no_start_a", 128'(eng_job_start), 128'(0));
    tick();
    chk("bad_no_start_b", 128'(eng_job_start), 128'(0));
    tick();
    chk("after_bad_start", 128'(eng_job_start), 128'(2'b01));
    chk("after_bad_bffr1", 128'(eng_job_data[15:0]), 128'(16'h00AA));
    lb_rd_chk("status_bad", 8'h01, 32'h000A_0000);
    eng_busy = 2'b01;
    tick();
    eng_busy = 2'b00;
    tick();

    // ---- flush three queued jobs while a job runs
    lb_wr(8'h08, 32'h0);
    tick();
    chk("flush_job_start", 128'(eng_job_start), 128'(2'b01));
    eng_busy = 2'b01;
    tick();
    tick();
    for (int i = 0; i < 3; i++) lb_wr(8'h08, 32'h0);
    lb_rd_chk("status_run_q3", 8'h01, 32'h0000_0301);
    lb_wr(8'h00, 32'h3);
    lb_rd_chk("status_run_flushed", 8'h01, 32'h0002_0001);
    eng_busy = 2'b00;
    start_acc = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      start_acc = start_acc | eng_job_start;
    end
    chk("no_start_after_flush", 128'(start_acc), 128'(0));
    chk("job_completed_idle",   128'(eng_ready), 128'(0));

    // ---- engine never asserts busy
    lb_wr(8'h08, 32'h0);
    tick();
    chk("tmo_job_start", 128'(eng_job_start), 128'(2'b01));
    for (int i = 0; i < 300; i++) tick();
`ifdef SYN_GPU_JOB_SCHED_TIMEOUT_EN
    chk("tmo_ready_idle", 128'(eng_ready), 128'(2'b00));
    lb_rd_chk("status_tmo", 8'h01, 32'h0012_0000);
`else
    chk("hold_ready_wait", 128'(eng_ready), 128'(2'b01));
    lb_rd_chk("status_hold", 8'h01, 32'h0002_0000);
`endif
    lb_wr(8'h08, 32'h0);
    tick();
    tick();
`ifdef SYN_GPU_JOB_SCHED_TIMEOUT_EN
    lb_rd_chk("status_tmo_next", 8'h01, 32'h0002_0000);
`else
    lb_rd_chk("status_hold_q1", 8'h01, 32'h0000_0100);
`endif

    // ---- synchronous reset mid-job
    rst_sync_l = 1'b0;
    tick();
    chk("midrst_ready",    128'(eng_ready), 128'(0));
    chk("midrst_gw_rdv",   128'(gw_pxl_rd_valid), 128'(0));
    chk("midrst_job_data", 128'(eng_job_data), 128'(0));
    chk("midrst_rd_data",  128'(lb_rd_data), 128'(0));
    rst_sync_l = 1'b1;
    tick();
    lb_rd_chk("status_after_rst", 8'h01, 32'h0002_0000);
    lb_rd_chk("ctrl_after_rst",   8'h00, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
